// File: rtl/video_pkg.sv
// video_pkg: shared types and helpers for the video frame ring.
//   ring_state_t : playback state (EMPTY, PRIME, PLAY)
//   frame_pix    : stored pixels per downscaled frame
//   is_frame_end : true on the last active VGA pixel of a frame
package video_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    PRIME = 2'd1,
    PLAY  = 2'd2
  } ring_state_t;

  function automatic int frame_pix(input int width, input int height, input int shift);
    return (width >> shift) * (height >> shift);
  endfunction

  function automatic logic is_frame_end(input logic en, input int x, input int y,
                                        input int width, input int height);
    return en && (x == width - 1) && (y == height - 1);
  endfunction

endpackage

// File: rtl/frame_ring_mem.sv
// frame_ring_mem: simple dual-port frame store, one write and one read port.
//   CLK_40  : clock
//   we      : write enable, wr_data stored at wr_addr
//   re      : read enable, rd_data loads mem[rd_addr] on the next edge
// No reset so the array maps onto block RAM.
module frame_ring_mem #(
  parameter int DATA_W = 1,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              CLK_40,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              re,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge CLK_40) begin
    if (we) mem[wr_addr] <= wr_data;
    if (re) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/video_frame_ring.sv
// video_frame_ring: circular buffer of downscaled video frames between the
// SPI pixel writer and the VGA pixel reader.
//   CLK_40, reset            : clock, synchronous active-high reset
//   wr_pixel_en/valid/data   : raster-order pixel writes, wr_ready = free slot
//   rd_pixel_en, VGA_x/y_pos : VGA scan position; rd_data registered pixel
//   frame_count              : committed frames held (incl. the one on display)
//   playing                  : high in PLAY
//   frame_done / underrun    : one-cycle pulses at a release / a missed release
//
// state | meaning
// EMPTY | no committed frame
// PRIME | frames being collected, waiting for threshold at a frame boundary
// PLAY  | displaying; releases a frame every FRAME_REPEAT VGA frames
module video_frame_ring
  import video_pkg::*;
#(
  parameter int WIDTH        = 640,
  parameter int HEIGHT       = 480,
  parameter int SCALE_SHIFT  = 2,
  parameter int NUM_FRAMES   = 15,
  parameter int PIX_BITS     = 1,
  parameter int PRIME_FRAMES = 2,
  parameter int FRAME_REPEAT = 1
) (
  input  logic                            CLK_40,
  input  logic                            reset,
  input  logic                            wr_pixel_en,
  input  logic                            wr_valid,
  input  logic [PIX_BITS-1:0]             wr_data,
  output logic                            wr_ready,
  input  logic                            rd_pixel_en,
  input  logic [$clog2(WIDTH)-1:0]        VGA_x_pos,
  input  logic [$clog2(HEIGHT)-1:0]       VGA_y_pos,
  output logic [PIX_BITS-1:0]             rd_data,
  output logic [$clog2(NUM_FRAMES+1)-1:0] frame_count,
  output logic                            playing,
  output logic                            frame_done,
  output logic                            underrun
);

  localparam int X_WIDTH   = WIDTH >> SCALE_SHIFT;
  localparam int Y_HEIGHT  = HEIGHT >> SCALE_SHIFT;
  localparam int FRAME_PIX = frame_pix(WIDTH, HEIGHT, SCALE_SHIFT);
  localparam int DEPTH     = NUM_FRAMES * FRAME_PIX;
  localparam int ADDR_W    = $clog2(DEPTH);
  localparam int XW        = (X_WIDTH > 1) ? $clog2(X_WIDTH) : 1;
  localparam int YW        = (Y_HEIGHT > 1) ? $clog2(Y_HEIGHT) : 1;
  localparam int PTR_W     = $clog2(NUM_FRAMES);
  localparam int FC_W      = $clog2(NUM_FRAMES + 1);
  localparam int RPT_W     = (FRAME_REPEAT > 1) ? $clog2(FRAME_REPEAT) : 1;

  localparam logic [XW-1:0]    X_LAST   = XW'(X_WIDTH - 1);
  localparam logic [YW-1:0]    Y_LAST   = YW'(Y_HEIGHT - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_FRAMES - 1);
  localparam logic [FC_W-1:0]  FC_FULL  = FC_W'(NUM_FRAMES);
  localparam logic [FC_W-1:0]  FC_PRIME = FC_W'(PRIME_FRAMES);
  localparam logic [FC_W-1:0]  FC_TWO   = FC_W'(2);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(FRAME_REPEAT - 1);

  ring_state_t       state, state_nxt;
  logic [XW-1:0]     wr_x;
  logic [YW-1:0]     wr_y;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [RPT_W-1:0]  repeat_cnt, rpt_nxt;
  logic              rel_frame, underrun_nxt;
  logic              accept, commit, frame_end;
  logic              rd_play_q;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [PIX_BITS-1:0] mem_q;

  assign wr_ready  = (frame_count < FC_FULL);
  assign accept    = wr_pixel_en & wr_valid & wr_ready;
  assign commit    = accept & (wr_x == X_LAST) & (wr_y == Y_LAST);
  assign frame_end = is_frame_end(rd_pixel_en, int'(VGA_x_pos), int'(VGA_y_pos), WIDTH, HEIGHT);
  assign playing   = (state == PLAY);

  // Linear addressing equals {ptr, y, x} for power-of-two frame dimensions
  // and stays dense for other sizes.
  assign wr_addr = ADDR_W'(int'(wr_ptr) * FRAME_PIX + int'(wr_y) * X_WIDTH + int'(wr_x));
  assign rd_addr = ADDR_W'(int'(rd_ptr) * FRAME_PIX
                           + int'(VGA_y_pos >> SCALE_SHIFT) * X_WIDTH
                           + int'(VGA_x_pos >> SCALE_SHIFT));

  frame_ring_mem #(
    .DATA_W (PIX_BITS),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .CLK_40  (CLK_40),
    .we      (accept),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .re      (rd_pixel_en),
    .rd_addr (rd_addr),
    .rd_data (mem_q)
  );

  // Memory output is gated by the state at read time, so the pixel is blanked
  // until playback starts and after reset without clearing the RAM.
  assign rd_data = rd_play_q ? mem_q : '0;

  always_ff @(posedge CLK_40) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    rpt_nxt      = repeat_cnt;
    rel_frame    = 1'b0;
    underrun_nxt = 1'b0;
    case (state)
      EMPTY: if (commit) state_nxt = PRIME;
      PRIME: begin
        if (frame_end && frame_count >= FC_PRIME) begin
          state_nxt = PLAY;
          rpt_nxt   = '0;
        end
      end
      PLAY: begin
        if (frame_end) begin
          if (repeat_cnt < RPT_LAST) begin
            rpt_nxt = repeat_cnt + 1'b1;
          end else if (frame_count >= FC_TWO) begin
            rel_frame = 1'b1;
            rpt_nxt   = '0;
          end else begin
            // hold the frame and keep repeat_cnt so the release retries
            underrun_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge CLK_40) begin
    if (reset) begin
      wr_x        <= '0;
      wr_y        <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      repeat_cnt  <= '0;
      frame_count <= '0;
      rd_play_q   <= 1'b0;
      frame_done  <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      repeat_cnt <= rpt_nxt;
      frame_done <= rel_frame;
      underrun   <= underrun_nxt;
      if (rd_pixel_en) rd_play_q <= (state == PLAY);
      if (accept) begin
        if (wr_x == X_LAST) begin
          wr_x <= '0;
          if (wr_y == Y_LAST) begin
            wr_y   <= '0;
            wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
          end else begin
            wr_y <= wr_y + 1'b1;
          end
        end else begin
          wr_x <= wr_x + 1'b1;
        end
      end
      if (rel_frame) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      case ({commit, rel_frame})
        2'b10:   frame_count <= frame_count + 1'b1;
        2'b01:   frame_count <= frame_count - 1'b1;
        default: frame_count <= frame_count;
      endcase
    end
  end

endmodule

// File: tb/tb_video_frame_ring.sv
module tb_video_frame_ring;
  import video_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_pixel_en, wr_valid;
  logic [0:0] wr_data;
  logic       wr_ready;
  logic       rd_pixel_en;
  logic [3:0] vga_x;
  logic [2:0] vga_y;
  logic [0:0] rd_data;
  logic [1:0] frame_count;
  logic       playing, frame_done, underrun;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  video_frame_ring #(
    .WIDTH(16), .HEIGHT(8), .SCALE_SHIFT(2), .NUM_FRAMES(3),
    .PIX_BITS(1), .PRIME_FRAMES(2), .FRAME_REPEAT(2)
  ) dut (
    .CLK_40      (clk),
    .reset       (reset),
    .wr_pixel_en (wr_pixel_en),
    .wr_valid    (wr_valid),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .rd_pixel_en (rd_pixel_en),
    .VGA_x_pos   (vga_x),
    .VGA_y_pos   (vga_y),
    .rd_data     (rd_data),
    .frame_count (frame_count),
    .playing     (playing),
    .frame_done  (frame_done),
    .underrun    (underrun)
  );

  typedef struct {
    logic en;
    logic valid;
    logic data;
    int   exp_x;
    int   exp_fc;
    logic exp_ready;
  } wvec_t;

  wvec_t tbl [10];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic write_pixels(input logic [7:0] pat, input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      wr_pixel_en = 1'b1;
      wr_valid    = 1'b1;
      wr_data     = pat[i];
      @(posedge clk); #1;
    end
    wr_pixel_en = 1'b0;
    wr_valid    = 1'b0;
  endtask

  // One full VGA frame at one pixel per clock. exp_play is the state seen by
  // every read of this frame; the rest are expectations right after its end.
  task automatic vga_frame(input string tag, input logic [7:0] pat, input bit exp_play,
                           input bit exp_play_after, input int exp_fc, input bit exp_done,
                           input bit exp_under, input bit wr_last, input logic last_data);
    logic exp_pix;
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 16; x++) begin
        rd_pixel_en = 1'b1;
        vga_x = 4'(x);
        vga_y = 3'(y);
        if (wr_last && x == 15 && y == 7) begin
          wr_pixel_en = 1'b1;
          wr_valid    = 1'b1;
          wr_data     = last_data;
        end
        @(posedge clk); #1;
        exp_pix = exp_play ? pat[(y >> 2) * 4 + (x >> 2)] : 1'b0;
        chk({tag, "/rd_data"}, int'(rd_data), int'(exp_pix));
      end
    end
    chk({tag, "/frame_done"}, int'(frame_done), int'(exp_done));
    chk({tag, "/underrun"}, int'(underrun), int'(exp_under));
    chk({tag, "/playing"}, int'(playing), int'(exp_play_after));
    chk({tag, "/frame_count"}, int'(frame_count), exp_fc);
    rd_pixel_en = 1'b0;
    if (wr_last) begin
      wr_pixel_en = 1'b0;
      wr_valid    = 1'b0;
    end
    @(posedge clk); #1;
    chk({tag, "/done_pulse_end"}, int'(frame_done), 0);
    chk({tag, "/under_pulse_end"}, int'(underrun), 0);
  endtask

  initial begin
    // frame A = 0x5A written with stalls on enable and on valid
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1, 0, 1'b1};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1, 0, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1, 0, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 2, 0, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 3, 0, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 0, 0, 1'b1};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 1, 0, 1'b1};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 2, 0, 1'b1};
    tbl[8] = '{1'b1, 1'b1, 1'b1, 3, 0, 1'b1};
    tbl[9] = '{1'b1, 1'b1, 1'b0, 0, 1, 1'b1};

    reset = 1'b1; wr_pixel_en = 1'b0; wr_valid = 1'b0; wr_data = 1'b0;
    rd_pixel_en = 1'b0; vga_x = '0; vga_y = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst/frame_count", int'(frame_count), 0);
    chk("rst/rd_data", int'(rd_data), 0);
    chk("rst/playing", int'(playing), 0);
    chk("rst/wr_ready", int'(wr_ready), 1);
    reset = 1'b0;

    // VGA with no writes stays idle
    vga_frame("empty", 8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("empty/state", int'(dut.state), int'(EMPTY));

    // table-driven write of frame A
    for (int i = 0; i < 10; i++) begin
      wr_pixel_en = tbl[i].en;
      wr_valid    = tbl[i].valid;
      wr_data     = tbl[i].data;
      @(posedge clk); #1;
      chk($sformatf("tblA%0d/wr_x", i), int'(dut.wr_x), tbl[i].exp_x);
      chk($sformatf("tblA%0d/fc", i), int'(frame_count), tbl[i].exp_fc);
      chk($sformatf("tblA%0d/ready", i), int'(wr_ready), int'(tbl[i].exp_ready));
    end
    wr_pixel_en = 1'b0; wr_valid = 1'b0;
    chk("A/state", int'(dut.state), int'(PRIME));

    write_pixels(8'hC3, 0, 8);
    chk("B/frame_count", int'(frame_count), 2);
    chk("B/wr_ptr", int'(dut.wr_ptr), 2);

    vga_frame("prime1", 8'h00, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    vga_frame("A1", 8'h5A, 1'b1, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    vga_frame("A2", 8'h5A, 1'b1, 1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    vga_frame("B1", 8'hC3, 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    vga_frame("B2", 8'hC3, 1'b1, 1'b1, 1, 1'b0, 1'b1, 1'b0, 1'b0);
    vga_frame("B3", 8'hC3, 1'b1, 1'b1, 1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("B3/rd_ptr", int'(dut.rd_ptr), 1);

    // fill all three slots with no reads
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    write_pixels(8'h96, 0, 8);
    write_pixels(8'h3C, 0, 8);
    write_pixels(8'hE1, 0, 8);
    chk("full/wr_ready", int'(wr_ready), 0);
    chk("full/frame_count", int'(frame_count), 3);
    chk("full/wr_ptr_wrap", int'(dut.wr_ptr), 0);
    wr_pixel_en = 1'b1; wr_valid = 1'b1; wr_data = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("full/wr_x_held", int'(dut.wr_x), 0);
    chk("full/fc_held", int'(frame_count), 3);
    vga_frame("prime2", 8'h00, 1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("prime2/wr_x_held", int'(dut.wr_x), 0);
    vga_frame("C1", 8'h96, 1'b1, 1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b0);
    vga_frame("C2", 8'h96, 1'b1, 1'b1, 2, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("C2/wr_x_accepted", int'(dut.wr_x), 1);
    wr_pixel_en = 1'b0; wr_valid = 1'b0;

    // commit of F lands on the release edge of D
    vga_frame("D1", 8'h3C, 1'b1, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    write_pixels(8'h69, 1, 6);
    chk("F6/wr_x", int'(dut.wr_x), 3);
    chk("F6/wr_y", int'(dut.wr_y), 1);
    vga_frame("D2", 8'h3C, 1'b1, 1'b1, 2, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("same/wr_ptr", int'(dut.wr_ptr), 1);
    chk("same/rd_ptr", int'(dut.rd_ptr), 2);
    chk("same/wr_x", int'(dut.wr_x), 0);
    chk("same/wr_y", int'(dut.wr_y), 0);
    vga_frame("E1", 8'hE1, 1'b1, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    vga_frame("E2", 8'hE1, 1'b1, 1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("wrap/rd_ptr", int'(dut.rd_ptr), 0);
    vga_frame("F1", 8'h69, 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    vga_frame("F2", 8'h69, 1'b1, 1'b1, 1, 1'b0, 1'b1, 1'b0, 1'b0);

    // reset while writing pixel 5 and reading
    write_pixels(8'h0F, 0, 4);
    wr_pixel_en = 1'b1; wr_valid = 1'b1; wr_data = 1'b0;
    rd_pixel_en = 1'b1; vga_x = 4'd5; vga_y = 3'd5;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; wr_pixel_en = 1'b0; wr_valid = 1'b0; rd_pixel_en = 1'b0;
    chk("midrst/frame_count", int'(frame_count), 0);
    chk("midrst/playing", int'(playing), 0);
    chk("midrst/rd_data", int'(rd_data), 0);
    chk("midrst/frame_done", int'(frame_done), 0);
    chk("midrst/underrun", int'(underrun), 0);
    chk("midrst/wr_x", int'(dut.wr_x), 0);
    chk("midrst/wr_y", int'(dut.wr_y), 0);
    chk("midrst/wr_ptr", int'(dut.wr_ptr), 0);
    chk("midrst/rd_ptr", int'(dut.rd_ptr), 0);
    chk("midrst/repeat_cnt", int'(dut.repeat_cnt), 0);
    chk("midrst/state", int'(dut.state), int'(EMPTY));

    write_pixels(8'h0F, 0, 8);
    write_pixels(8'hF0, 0, 8);
    chk("reprime/frame_count", int'(frame_count), 2);
    vga_frame("prime3", 8'h00, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    vga_frame("G1", 8'h0F, 1'b1, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/video_frame_ring.md
Name: video_frame_ring

Overview:
- Parametrised successor to the fixed 15-frame, divide-by-4, fill-then-drain video bank.
- Circular buffer of NUM_FRAMES downscaled frames, PIX_BITS per pixel: the SPI writer fills frames while the VGA reader displays older ones.
- Adds a per-pixel write handshake, a priming threshold before playback, per-frame repeat for frame-rate conversion, and underrun handling by holding the last frame.
- Sits between the SPI pixel deserialiser and the VGA pixel pipeline.

Parameters:
- WIDTH, 640, VGA active width.
- HEIGHT, 480, VGA active height.
- SCALE_SHIFT, 2, log2 of the downscale factor; X_WIDTH = WIDTH>>SCALE_SHIFT, Y_HEIGHT = HEIGHT>>SCALE_SHIFT.
- NUM_FRAMES, 15, frame slots in the ring; minimum 2.
- PIX_BITS, 1, bits per stored pixel.
- PRIME_FRAMES, 2, committed frames required before playback starts; range 1..NUM_FRAMES.
- FRAME_REPEAT, 1, VGA frames shown per stored frame; minimum 1.

Ports:
- CLK_40  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- wr_pixel_en  in  1  write-side clock enable (SPI rate).
- wr_valid  in  1  wr_data holds a valid pixel.
- wr_data  in  PIX_BITS  pixel value; raster order.
- wr_ready  out  1  a free slot exists, so a pixel can be accepted.
- rd_pixel_en  in  1  read-side clock enable (VGA pixel rate).
- VGA_x_pos  in  $clog2(WIDTH)  current VGA column.
- VGA_y_pos  in  $clog2(HEIGHT)  current VGA row.
- rd_data  out  PIX_BITS  displayed pixel, registered.
- frame_count  out  $clog2(NUM_FRAMES+1)  committed frames held, including the one on display.
- playing  out  1  high in PLAY.
- frame_done  out  1  one-cycle pulse when a displayed frame is released.
- underrun  out  1  one-cycle pulse when a release was due but no next frame was ready.

Behaviour:
- Reset values: wr_x, wr_y, wr_ptr, rd_ptr, repeat_cnt and frame_count are 0; rd_data, frame_done and underrun are 0; state is EMPTY.
- Reset mid-operation discards every frame, including a partly written one. Memory contents are not cleared.
- wr_ready = (frame_count < NUM_FRAMES). It is combinational and does not depend on wr_valid.
- Pixel accept = wr_pixel_en & wr_valid & wr_ready.
  - On accept, write wr_data to {wr_ptr, wr_y, wr_x}, then increment wr_x.
  - At wr_x = X_WIDTH-1, wr_x goes to 0 and wr_y increments.
  - At the last pixel (X_WIDTH-1, Y_HEIGHT-1), wr_x and wr_y go to 0, wr_ptr advances modulo NUM_FRAMES, and frame_count increments (commit).
- Read address = {rd_ptr, VGA_y_pos>>SCALE_SHIFT, VGA_x_pos>>SCALE_SHIFT}.
  - On rd_pixel_en, rd_data updates one CLK_40 cycle later.
  - rd_data is the stored pixel in PLAY and 0 otherwise.
- VGA frame end = rd_pixel_en & VGA_x_pos==WIDTH-1 & VGA_y_pos==HEIGHT-1.
- State machine:
  - EMPTY: frame_count==0. Go to PRIME on the first commit.
  - PRIME: go to PLAY on a VGA frame end with frame_count>=PRIME_FRAMES. This aligns playback start to a frame boundary; repeat_cnt = 0.
  - PLAY, at each VGA frame end:
    - If repeat_cnt < FRAME_REPEAT-1: repeat_cnt++.
    - Else if frame_count>=2: release. rd_ptr advances modulo NUM_FRAMES, frame_count decrements, repeat_cnt = 0, frame_done pulses.
    - Else: underrun pulses, the same frame is shown again, and repeat_cnt holds so the release is retried at the next frame end.
  - PLAY never leaves except on reset.
- A commit and a release in the same cycle leave frame_count unchanged; both pointers still move.
- The slot being written is never the displayed slot, because wr_ready requires a free slot.
- Pointer wrap: NUM_FRAMES-1 goes to 0. Non-power-of-2 NUM_FRAMES is required to work.

Decomposition:
- Package video_pkg holds:
  - the state enum typedef (EMPTY, PRIME, PLAY);
  - the FRAME_PIX = X_WIDTH*Y_HEIGHT localparam helper function;
  - the frame-end compare function.
- Sub-module frame_ring_mem: simple dual-port memory with PIX_BITS width and NUM_FRAMES*FRAME_PIX depth.
  - Synchronous write on CLK_40 when we.
  - Synchronous read when re.
  - No reset, so it stays inferable as block RAM.
- Ring pointers, counters and the state machine live in video_frame_ring.

Test Plan:
Common parameters: WIDTH=16, HEIGHT=8, SCALE_SHIFT=2 (4x2 = 8 pixels per frame), NUM_FRAMES=3, PRIME_FRAMES=2, FRAME_REPEAT=2.
- Reset, then VGA runs with no writes -> state EMPTY, rd_data=0, playing=0, frame_count=0 throughout.
- Write frame A (0x5A pattern), then frame B -> frame_count=2. At the next VGA frame end, playing=1; rd_data shows A pixel (x>>2, y>>2) one cycle after each rd_pixel_en.
- With A and B queued, run 4 VGA frames -> A is shown twice. frame_done pulses at the end of the 2nd frame, then B is shown twice. At the 4th frame end, underrun pulses and B is held.
- Write 3 frames with no reads -> wr_ready=0 after the 24th accepted pixel. A 25th wr_valid is ignored (wr_x stays 0) until a release drops frame_count to 2.
- A commit and a release land in the same CLK_40 cycle -> frame_count is unchanged, wr_ptr and rd_ptr both advance, and pointers wrap 2->0.
- Assert reset mid-frame while writing pixel 5 and playing -> all outputs and pointers are 0 and the state is EMPTY next cycle. Re-prime works normally afterwards.
